// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-file signal bundle for spi_cmd_decoder.
// The decoder takes the master modport. It drives the register strobes and returns read data to the bridge.
interface spi_cmd_decoder_if #(
  parameter int ADDR_W = 6
);
  logic              cs_n;
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_write;
  logic [7:0]        data_read;

  modport master (
    input  cs_n, byte_sync, data_in, data_read,
    output data_out, read, write, addr, data_write
  );

  modport slave (
    output cs_n, byte_sync, data_in, data_read,
    input  data_out, read, write, addr, data_write
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Turns the SPI bridge byte stream into one-cycle register-file read/write strobes.
// Auto-increment bursts are supported within a single chip-select frame.
module spi_cmd_decoder #(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_cmd_decoder_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              dir_q, ai_q, first_q;
  logic              read_q, write_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_write_q, data_out_q;

  logic              cmd_load;
  logic              rd_req;
  logic              wr_req;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cmd_load = 1'b0;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr_d   = addr_q;

    if (bus.cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.byte_sync) begin
            cmd_load = 1'b1;
            state_d  = bus.data_in[7] ? WR_DATA : RD_DATA;
            // A read command issues its first access straight away, so the data is ready for the next byte.
            rd_req   = ~bus.data_in[7];
          end
        end
        WR_DATA: wr_req = bus.byte_sync & dir_q;
        RD_DATA: rd_req = bus.byte_sync & ~dir_q;
        default: state_d = IDLE;
      endcase
    end

    // The first access targets the command address. Each later access steps only when ai is set.
    if (cmd_load) begin
      addr_d = bus.data_in[ADDR_W-1:0];
    end else if ((rd_req | wr_req) && ai_q && !first_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q        <= 1'b0;
      ai_q         <= 1'b0;
      first_q      <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_write_q <= '0;
      data_out_q   <= '0;
    end else begin
      read_q  <= rd_req;
      write_q <= wr_req;
      addr_q  <= addr_d;

      if (cmd_load) begin
        dir_q   <= bus.data_in[7];
        ai_q    <= bus.data_in[6];
        first_q <= 1'b1;
      end else if (read_q || write_q) begin
        first_q <= 1'b0;
      end

      if (wr_req) begin
        data_write_q <= bus.data_in;
      end

      // Register-file data is valid during the read strobe. It is held here until the next read.
      if (read_q) begin
        data_out_q <= bus.data_read;
      end
    end
  end

  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = data_write_q;
  assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed scoreboard bench for spi_cmd_decoder.
// The bench predicts each strobe when it sends a byte, and a negedge monitor compares each strobe as it appears.
module tb_spi_cmd_decoder;

  localparam int ADDR_W = 6;

  typedef struct {
    bit              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]      data;
  } exp_t;

  logic clk;
  logic rst_n;

  spi_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_decoder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] regs [64];
  assign bus.data_read = regs[bus.addr];

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         dout_pending = 0;
  logic [7:0] dout_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples strobes midway between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_pending) begin
        check("data_out", bus.data_out, dout_exp);
        dout_pending = 0;
      end
      if (bus.read || bus.write) begin
        check("strobe_excl", bus.read & bus.write, 0);
        if (sb.size() == 0) begin
          check("unexpected_strobe", {bus.read, bus.write}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_kind", bus.write, e.is_wr);
          check("strobe_addr", bus.addr, e.addr);
          if (e.is_wr) begin
            check("data_write", bus.data_write, e.data);
          end else begin
            dout_pending = 1;
            dout_exp     = e.data;
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_t e;
    e.is_wr = 1; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.is_wr = 0; e.addr = a; e.data = regs[a];
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.data_in   = b;
    bus.byte_sync = 1'b1;
    @(posedge clk); #1;
    bus.byte_sync = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic cs_set(input logic v);
    @(posedge clk); #1;
    bus.cs_n = v;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_read"},       bus.read,       0);
    check({tag, "_write"},      bus.write,      0);
    check({tag, "_addr"},       bus.addr,       0);
    check({tag, "_data_write"}, bus.data_write, 0);
    check({tag, "_data_out"},   bus.data_out,   0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'(i * 37 + 11);
    regs[7] = 8'hA5;

    rst_n         = 1'b0;
    bus.cs_n      = 1'b1;
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write: no read strobe, one write at address 5.
    cs_set(1'b0);
    push_wr(6'd5, 8'h3C);
    send_byte(8'h85);
    send_byte(8'h3C);
    cs_set(1'b1);

    // Auto-increment write burst.
    cs_set(1'b0);
    push_wr(6'd3, 8'h11); push_wr(6'd4, 8'h22); push_wr(6'd5, 8'h33);
    send_byte(8'hC3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cs_set(1'b1);

    // Burst that wraps from 63 to 0.
    cs_set(1'b0);
    push_wr(6'd62, 8'hA1); push_wr(6'd63, 8'hA2); push_wr(6'd0, 8'hA3);
    send_byte(8'hFE);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    cs_set(1'b1);

    // Single read from address 7, followed by an auto-increment read burst.
    cs_set(1'b0);
    push_rd(6'd7);
    send_byte(8'h07);
    cs_set(1'b1);

    cs_set(1'b0);
    push_rd(6'd7); push_rd(6'd8); push_rd(6'd9);
    send_byte(8'h47);
    send_byte(8'h00); send_byte(8'h00);
    cs_set(1'b1);

    // Abort between command and data: no write. The next frame starts with a command.
    cs_set(1'b0);
    send_byte(8'h82);
    cs_set(1'b1);
    cs_set(1'b0);
    push_rd(6'd1);
    send_byte(8'h01);
    cs_set(1'b1);

    // Collision: byte_sync in the same cycle as cs_n rising is dropped.
    cs_set(1'b0);
    send_byte(8'h81);
    @(posedge clk); #1;
    bus.cs_n      = 1'b1;
    bus.byte_sync = 1'b1;
    bus.data_in   = 8'h99;
    @(posedge clk); #1;
    bus.byte_sync = 1'b0;
    repeat (6) @(posedge clk);

    // Non-auto-increment burst: both writes land at address 10.
    cs_set(1'b0);
    push_wr(6'd10, 8'h01); push_wr(6'd10, 8'h02);
    send_byte(8'h8A);
    send_byte(8'h01); send_byte(8'h02);
    cs_set(1'b1);

    // Reset mid-burst, asserted while a write strobe is still high.
    cs_set(1'b0);
    push_wr(6'd3, 8'h11);
    send_byte(8'hC3);
    send_byte(8'h11);
    @(posedge clk); #1;
    bus.data_in   = 8'h22;
    bus.byte_sync = 1'b1;
    @(posedge clk); #1;
    bus.byte_sync = 1'b0;
    check("pre_reset_write", bus.write, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // After release the decoder is IDLE, so the first byte is taken as a command.
    push_wr(6'd5, 8'h3C);
    send_byte(8'h85);
    send_byte(8'h3C);
    cs_set(1'b1);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI byte bridge and converts its byte stream into register-file accesses for the PWM generator.
- Consumes byte_sync/data_in from the bridge and returns read data on data_out to the bridge.
- Decodes a command byte, then issues one-cycle read/write strobes with address and data. Supports auto-increment bursts within one chip-select frame.

Parameters:
- ADDR_W, 6, register address width; the command byte carries it in bits [ADDR_W-1:0]. Fixed at 6 for the 8-bit command format.

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  asynchronous active-low reset
- cs_n  input  1  SPI chip select, already synchronous to clk; high = no frame
- byte_sync  input  1  one-cycle pulse from the bridge: data_in holds a new byte
- data_in  input  8  received byte
- data_out  output  8  read data presented to the bridge for transmission
- read  output  1  one-cycle read strobe to the register file
- write  output  1  one-cycle write strobe to the register file
- addr  output  ADDR_W  register address, valid while read or write is high
- data_write  output  8  write data, valid while write is high
- data_read  input  8  register-file read data, combinational from addr, valid in the read-strobe cycle

Behaviour:
- Clock, reset and sequencing:
  - Single clock domain, clk. rst_n is asynchronous and active-low.
  - Reset values: read=0, write=0, addr=0, data_write=0, data_out=0, state=IDLE, first=0, dir=0, ai=0.
- Command byte format:
  - bit7 dir: 1 = write, 0 = read.
  - bit6 ai: 1 = auto-increment.
  - bits5:0 start address.
- State machine: IDLE, WR_DATA, RD_DATA.
  - IDLE: byte_sync with cs_n low captures the command. Next state is WR_DATA if dir=1, RD_DATA if dir=0.
  - Any state: cs_n high forces IDLE on the next edge, and read/write go low.
  - addr, data_write and data_out hold their values across cs_n.
- Read frame:
  - Command byte_sync in cycle T.
  - T+1: state=RD_DATA, addr=cmd[5:0], read=1.
  - T+2: data_out = data_read sampled at the end of T+1, held until the next read.
  - Each later byte_sync in RD_DATA (cycle T'): T'+1 read=1 with addr=addr+1 if ai, else unchanged; T'+2 data_out updated.
  - Consequence: burst access n (n=0 first) always targets start+n when ai=1.
- Write frame:
  - Each byte_sync in WR_DATA (cycle T'): T'+1 write=1, data_write=data_in captured at T'.
  - First data byte after the command: addr=cmd[5:0].
  - Later data bytes: addr=addr+1 if ai, else unchanged.
  - First-access tracking uses internal flag first, set on command decode and cleared on the first strobe.
- Address arithmetic: ADDR_W-bit modulo increment; 63 wraps to 0 with no error.
- Strobes:
  - Exactly one cycle long; never asserted together.
  - Never asserted in a cycle where the registered cs_n was high at the preceding edge.
- Boundary conditions:
  - Simultaneous cs_n high and byte_sync: byte dropped, no strobe, go to IDLE.
  - byte_sync with cs_n high: ignored.
  - cs_n high between command and data byte: no write occurs.
  - A new frame always starts with a command byte.
  - Reset mid-frame: immediate return to reset values; no pending strobe survives.
  - Back-to-back byte_sync is at least 8 SPI bit times apart; no internal queueing required.
- Bridge timing: the bridge loads data_out at each byte boundary. Read data from the command byte is therefore shifted on MISO during the second byte after the command; hosts clock one dummy byte per read, plus one trailing byte.

Test Plan:
- Reset: assert rst_n=0 mid-burst -> all outputs 0 asynchronously; state IDLE after release.
- Single write: cs_n low, bytes 0x85, 0x3C -> one write pulse with addr=5, data_write=0x3C one cycle after the second byte_sync; no read pulse.
- AI write burst: 0xC3, 0x11, 0x22, 0x33 -> writes (3,0x11), (4,0x22), (5,0x33). Repeat with 0xFE -> (62,..), (63,..), (0,..) showing wrap.
- Read: 0x07 with data_read=0xA5 at addr 7 -> read pulse at T+1 with addr=7, data_out=0xA5 at T+2. With AI 0x47 plus 2 dummies -> reads at 7, 8, 9; data_out follows.
- Abort: 0x82 then cs_n high before the second byte -> no write. A new frame 0x01 is decoded as a read command, not data.
- Collision: byte_sync coincident with cs_n rising in WR_DATA -> no write, state IDLE; non-AI write burst 0x8A, 1, 2 -> two writes, both addr=10.
